// File: rtl/ultrasonic_ranger.sv
// HC-SR04 trigger/echo front-end: times the echo width, maps it to a speed band and PWM compare value.
// Optional MEDIAN3_FILTER_EN: band/pulse_width taken from the median of the last three raw widths.
module ultrasonic_ranger #(
   parameter int unsigned TRIG_CYCLES    = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 3802000,
   parameter int unsigned HOLDOFF_CYCLES = 5000000,
   parameter int unsigned BAND_CYCLES    = 475250,
   parameter int unsigned DUTY_STEP      = 62500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        echo,
   output logic        trig,
   output logic [22:0] echo_cycles,
   output logic [2:0]  band,
   output logic [18:0] pulse_width,
   output logic        timeout,
   output logic        valid,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_DONE, S_HOLDOFF
   } state_t;

   localparam logic [22:0] TRIG_C    = 23'(TRIG_CYCLES);
   localparam logic [22:0] TIMEOUT_C = 23'(TIMEOUT_CYCLES);
   localparam logic [22:0] HOLD_C    = 23'(HOLDOFF_CYCLES);
   localparam logic [22:0] B1_C      = 23'(BAND_CYCLES);
   localparam logic [22:0] B2_C      = 23'(2 * BAND_CYCLES);
   localparam logic [22:0] B3_C      = 23'(3 * BAND_CYCLES);
   localparam logic [18:0] DUTY_C    = 19'(DUTY_STEP);

   state_t      state_q, state_d;
   logic [22:0] cnt_q, cnt_d;
   logic [22:0] width_q, width_d;
   logic        tout_q, tout_d;
   logic        trig_q, trig_d;
   logic [2:0]  sync_q;
   logic [22:0] echo_cycles_q;
   logic [2:0]  band_q, band_d;
   logic [18:0] pw_q, pw_d;
   logic        timeout_q;
   logic        valid_q;
   logic        load;
   logic        echo_s, rise, fall;

   // sync_q[1] is the synchronised echo; sync_q[2] is its one-cycle-old copy for edge detection
   assign echo_s = sync_q[1];
   assign rise   = sync_q[1] & ~sync_q[2];
   assign fall   = ~sync_q[1] & sync_q[2];

   function automatic logic [2:0] band_of(input logic [22:0] w);
      logic [2:0] b;
      if (w == '0)        b = 3'd0;
      else if (w <= B1_C) b = 3'd1;
      else if (w <= B2_C) b = 3'd2;
      else if (w <= B3_C) b = 3'd3;
      else                b = 3'd4;
      return b;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         width_q <= '0;
         tout_q  <= 1'b0;
         trig_q  <= 1'b0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         width_q <= width_d;
         tout_q  <= tout_d;
         trig_q  <= trig_d;
         sync_q  <= {sync_q[1:0], echo};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      width_d = width_q;
      tout_d  = tout_q;
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_TRIG;
               cnt_d   = '0;
            end
         end
         S_TRIG: begin
            if (cnt_q >= TRIG_C - 23'd1) begin
               state_d = S_WAIT_RISE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 23'd1;
            end
         end
         S_WAIT_RISE: begin
            if (rise) begin
               state_d = S_MEASURE;
               cnt_d   = '0;
            end else if (cnt_q >= TIMEOUT_C - 23'd1) begin
               state_d = S_DONE;
               width_d = '0;
               tout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 23'd1;
            end
         end
         S_MEASURE: begin
            if (fall) begin
               state_d = S_DONE;
               width_d = cnt_q;
               tout_d  = 1'b0;
            end else if (cnt_q >= TIMEOUT_C) begin
               state_d = S_DONE;
               width_d = TIMEOUT_C;
               tout_d  = 1'b1;
            end else if (echo_s) begin
               cnt_d = cnt_q + 23'd1;
            end
         end
         S_DONE: begin
            state_d = S_HOLDOFF;
            cnt_d   = '0;
         end
         S_HOLDOFF: begin
            if (cnt_q >= HOLD_C - 23'd1) begin
               cnt_d   = '0;
               state_d = enable ? S_TRIG : S_IDLE;
            end else begin
               cnt_d = cnt_q + 23'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      trig_d = (state_d == S_TRIG);
   end

`ifdef MEDIAN3_FILTER_EN
   logic [22:0] hist_q [3];
   logic        pend_q;
   logic [22:0] lo, hi, med;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 3; i++) hist_q[i] <= '0;
         pend_q <= 1'b0;
      end else begin
         pend_q <= (state_q == S_DONE);
         if (state_q == S_DONE) begin
            hist_q[2] <= hist_q[1];
            hist_q[1] <= hist_q[0];
            hist_q[0] <= tout_q ? TIMEOUT_C : width_q;
         end
      end
   end

   always_comb begin
      lo     = (hist_q[0] < hist_q[1]) ? hist_q[0] : hist_q[1];
      hi     = (hist_q[0] < hist_q[1]) ? hist_q[1] : hist_q[0];
      med    = (hist_q[2] < lo) ? lo : ((hist_q[2] > hi) ? hi : hist_q[2]);
      load   = pend_q;
      band_d = band_of(med);
      pw_d   = DUTY_C * 19'(band_d);
   end
`else
   always_comb begin
      load   = (state_q == S_DONE);
      band_d = tout_q ? 3'd0 : band_of(width_q);
      pw_d   = DUTY_C * 19'(band_d);
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         echo_cycles_q <= '0;
         band_q        <= '0;
         pw_q          <= '0;
         timeout_q     <= 1'b0;
         valid_q       <= 1'b0;
      end else begin
         valid_q <= load;
         if (load) begin
            echo_cycles_q <= width_q;
            band_q        <= band_d;
            pw_q          <= pw_d;
            timeout_q     <= tout_q;
         end
      end
   end

   assign trig        = trig_q;
   assign echo_cycles = echo_cycles_q;
   assign band        = band_q;
   assign pulse_width = pw_q;
   assign timeout     = timeout_q;
   assign valid       = valid_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger with scaled-down timing parameters and an echo model.
module tb_ultrasonic_ranger;

   localparam int TRIG    = 10;
   localparam int TMO     = 2000;
   localparam int HOLD    = 40;
   localparam int BANDW   = 250;
   localparam int DUTY    = 62500;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        echo = 1'b0;
   logic        trig;
   logic [22:0] echo_cycles;
   logic [2:0]  band;
   logic [18:0] pulse_width;
   logic        timeout;
   logic        valid;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   int hist [3];

   ultrasonic_ranger #(
      .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HOLD),
      .BAND_CYCLES(BANDW), .DUTY_STEP(DUTY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo), .trig(trig),
      .echo_cycles(echo_cycles), .band(band), .pulse_width(pulse_width),
      .timeout(timeout), .valid(valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // band rule: ceil(w / BAND) clamped to 4, zero width is band 0
   function automatic int band_of(input int w);
      int b;
      if (w == 0) return 0;
      b = (w + BANDW - 1) / BANDW;
      return (b > 4) ? 4 : b;
   endfunction

   function automatic int median3(input int a, input int b, input int c);
      int s [3];
      int t;
      s[0] = a; s[1] = b; s[2] = c;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2 - i; j++)
            if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
      return s[1];
   endfunction

   task automatic clear_model();
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
   endtask

   // waits for trig to rise, then returns the number of cycles it stayed high
   task automatic wait_trig(output int len, output bit ok);
      ok = 1'b0;
      len = 0;
      for (int i = 0; i < 400; i++) begin
         if (trig) begin ok = 1'b1; break; end
         step();
      end
      if (!ok) return;
      while (trig && len < 200) begin len++; step(); end
   endtask

   // mode 0: echo pulse of hi cycles; 1: no echo; 2: echo stuck high
   task automatic run_meas(input string tag, input int mode, input int dly, input int hi, input bit drop_en);
      int  len, ew, eb, ep, m;
      bit  ok, et, got;
      wait_trig(len, ok);
      n_cmp++;
      if (!ok || len != TRIG) begin
         n_err++;
         $display("FAIL %s trig_len: got %0d (seen=%0b) want %0d", tag, len, ok, TRIG);
         return;
      end
      repeat (dly) step();
      if (mode == 0) begin
         echo = 1'b1;
         if (drop_en) enable = 1'b0;
         repeat (hi) step();
         echo = 1'b0;
         ew = hi - 1; et = 1'b0;
      end else if (mode == 2) begin
         echo = 1'b1;
         ew = TMO; et = 1'b1;
      end else begin
         ew = 0; et = 1'b1;
      end
`ifdef MEDIAN3_FILTER_EN
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = et ? TMO : ew;
      m  = median3(hist[0], hist[1], hist[2]);
      eb = band_of(m);
`else
      m  = ew;
      eb = et ? 0 : band_of(m);
`endif
      ep = eb * DUTY;
      got = 1'b0;
      for (int i = 0; i < TMO + 300; i++) begin
         if (valid) begin got = 1'b1; break; end
         step();
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL %s valid_seen: got 0 want 1", tag);
         echo = 1'b0;
         return;
      end
      n_cmp++;
      if (echo_cycles !== 23'(ew)) begin n_err++; $display("FAIL %s echo_cycles: got %0d want %0d", tag, echo_cycles, ew); end
      n_cmp++;
      if (band !== 3'(eb)) begin n_err++; $display("FAIL %s band: got %0d want %0d", tag, band, eb); end
      n_cmp++;
      if (pulse_width !== 19'(ep)) begin n_err++; $display("FAIL %s pulse_width: got %0d want %0d", tag, pulse_width, ep); end
      n_cmp++;
      if (timeout !== et) begin n_err++; $display("FAIL %s timeout: got %0b want %0b", tag, timeout, et); end
      step();
      n_cmp++;
      if (valid !== 1'b0) begin n_err++; $display("FAIL %s valid_one_cycle: got %0b want 0", tag, valid); end
      echo = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      n_cmp++;
      if ({trig, busy, valid, timeout} !== 4'b0 || echo_cycles !== '0 || band !== '0 || pulse_width !== '0) begin
         n_err++;
         $display("FAIL %s reset_outputs: got trig=%0b busy=%0b valid=%0b timeout=%0b echo_cycles=%0d band=%0d pw=%0d want all 0",
                  tag, trig, busy, valid, timeout, echo_cycles, band, pulse_width);
      end
   endtask

   task automatic test_reset();
      int trig_hi, busy_hi;
      rst_n = 1'b0; enable = 1'b0; echo = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      clear_model();
      step();
      check_zero("reset");
      trig_hi = 0; busy_hi = 0;
      for (int i = 0; i < 10000; i++) begin
         if (trig) trig_hi++;
         if (busy) busy_hi++;
         step();
      end
      n_cmp++;
      if (trig_hi != 0 || busy_hi != 0) begin
         n_err++;
         $display("FAIL reset_idle: got trig_hi=%0d busy_hi=%0d cycles want 0", trig_hi, busy_hi);
      end
   endtask

   task automatic test_basic();
      enable = 1'b1;
      run_meas("basic", 0, 50, 151, 1'b0);
   endtask

   task automatic test_band_edges();
      int ns [7];
      ns[0] = 1; ns[1] = 251; ns[2] = 252; ns[3] = 501; ns[4] = 502; ns[5] = 751; ns[6] = 752;
      enable = 1'b1;
      foreach (ns[k]) run_meas($sformatf("edge_%0d", ns[k] - 1), 0, 20, ns[k], 1'b0);
   endtask

   task automatic test_timeout();
      enable = 1'b1;
      run_meas("no_echo", 1, 0, 0, 1'b0);
      run_meas("stuck_high", 2, 30, 0, 1'b0);
   endtask

   task automatic test_random();
      enable = 1'b1;
      for (int k = 0; k < 10; k++)
         run_meas($sformatf("rand%0d", k), 0, int'($urandom_range(0, 300)), int'($urandom_range(1, 1900)), 1'b0);
   endtask

   task automatic test_enable_drop();
      int trig_hi;
      enable = 1'b1;
      run_meas("enable_drop", 0, 10, 400, 1'b1);
      trig_hi = 0;
      for (int i = 0; i < HOLD + 200; i++) begin
         if (trig) trig_hi++;
         step();
      end
      n_cmp++;
      if (trig_hi != 0) begin n_err++; $display("FAIL enable_drop_no_trig: got %0d trig cycles want 0", trig_hi); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL enable_drop_busy: got %0b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      int len;
      bit ok;
      enable = 1'b1;
      for (int i = 0; i < 400 && !trig; i++) step();
      repeat (3) step();
      rst_n = 1'b0;
      step();
      check_zero("reset_in_trig");
      rst_n = 1'b1;
      clear_model();
      wait_trig(len, ok);
      repeat (5) step();
      echo = 1'b1;
      repeat (20) step();
      rst_n = 1'b0;
      step();
      check_zero("reset_in_measure");
      echo = 1'b0;
      rst_n = 1'b1;
      clear_model();
      step();
   endtask

   task automatic test_median_seq();
      rst_n = 1'b0; enable = 1'b0;
      step();
      rst_n = 1'b1;
      clear_model();
      enable = 1'b1;
      run_meas("seq_a", 0, 15, 54, 1'b0);
      run_meas("seq_b", 0, 15, 790, 1'b0);
      run_meas("seq_c", 0, 15, 317, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_band_edges();
      test_timeout();
      test_random();
      test_enable_drop();
      test_reset_mid();
      test_median_seq();
      enable = 1'b0;
      repeat (HOLD + 20) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
